// File: rtl/input_conditioner.sv
// Synchronizes and debounces asynchronous switch/key inputs, producing clean
// levels plus single-cycle rise/fall strobes and a combined change pulse.
module input_conditioner #(
  parameter int                 NBITS           = 10,
  parameter int                 DEBOUNCE_CYCLES = 500000,
  parameter logic [NBITS-1:0]   INV_MASK        = NBITS'(10'b11_0000_0000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] raw,
  output logic [NBITS-1:0] stable,
  output logic [NBITS-1:0] rise,
  output logic [NBITS-1:0] fall,
  output logic             changed
);

  localparam int             CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [NBITS-1:0] w_x;
  logic [NBITS-1:0] w_accept;

  (* ASYNC_REG = "TRUE" *) logic [NBITS-1:0] r_s1;
  (* ASYNC_REG = "TRUE" *) logic [NBITS-1:0] r_s2;
  logic [NBITS-1:0] r_stable;
  logic [NBITS-1:0] r_rise;
  logic [NBITS-1:0] r_fall;
  logic             r_changed;
  logic [CW-1:0]    r_cnt [NBITS];

  assign w_x = raw ^ INV_MASK;

  // s1 feeds s2 directly: only s1 may go metastable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      // NOTE: non-blocking assignments make s1/s2 a true two-stage shift,
      // blocking ones would collapse them into a single flop.
      r_s1 <= w_x;
      r_s2 <= r_s1;
    end
  end

  // Each bit settles independently; its state is implied by s2 != stable.
  for (genvar i = 0; i < NBITS; i++) begin : g_bit
    assign w_accept[i] = (r_s2[i] != r_stable[i]) && (r_cnt[i] == TERM);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt[i] <= '0;
      end else if ((r_s2[i] == r_stable[i]) || w_accept[i]) begin
        r_cnt[i] <= '0;
      end else begin
        r_cnt[i] <= r_cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stable  <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_stable  <= r_stable ^ w_accept;
      r_rise    <= w_accept &  r_s2;
      r_fall    <= w_accept & ~r_s2;
      r_changed <= |w_accept;
    end
  end

  assign stable  = r_stable;
  assign rise    = r_rise;
  assign fall    = r_fall;
  assign changed = r_changed;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4; every edge of
// each scenario is compared against hand-derived stable/rise/fall/changed.
module tb_input_conditioner;

  localparam int NBITS = 10;
  localparam int DB    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [NBITS-1:0] raw;
  logic [NBITS-1:0] stable;
  logic [NBITS-1:0] rise;
  logic [NBITS-1:0] fall;
  logic             changed;

  int n_tests = 0;
  int n_fail  = 0;

  input_conditioner #(
    .NBITS           (NBITS),
    .DEBOUNCE_CYCLES (DB),
    .INV_MASK        (10'b11_0000_0000)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .raw     (raw),
    .stable  (stable),
    .rise    (rise),
    .fall    (fall),
    .changed (changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [30:0] obs, input logic [30:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed stable=%h rise=%h fall=%h changed=%b, expected stable=%h rise=%h fall=%h changed=%b",
             tag, obs[30:21], obs[20:11], obs[10:1], obs[0],
             exp[30:21], exp[20:11], exp[10:1], exp[0]);
    end
  endtask

  task automatic expect_out(input string tag, input logic [9:0] s, input logic [9:0] r,
                            input logic [9:0] f, input logic c);
    check(tag, {stable, rise, fall, changed}, {s, r, f, c});
  endtask

  // Sample 1 time unit after the rising edge; inputs are driven right after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [12:0] bounce;
    logic [9:0]  s_exp;
    logic [9:0]  r_exp;
    logic [9:0]  f_exp;

    // 1: reset with keys released, then 20 quiet cycles
    reset = 1'b1;
    raw   = 10'b11_0000_0000;
    #2;
    expect_out("reset_async", 10'h000, 10'h000, 10'h000, 1'b0);
    for (int e = 1; e <= 3; e++) begin
      tick();
      expect_out($sformatf("reset_hold_%0d", e), 10'h000, 10'h000, 10'h000, 1'b0);
    end
    reset = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      expect_out($sformatf("idle_%0d", e), 10'h000, 10'h000, 10'h000, 1'b0);
    end

    // 2: raw[0] goes high before edge 1, accepted at edge 6
    raw[0] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      expect_out($sformatf("sw0_edge%0d", e),
                 (e >= 6) ? 10'h001 : 10'h000,
                 (e == 6) ? 10'h001 : 10'h000,
                 10'h000, e == 6);
    end

    // 3: bounce on raw[3]; final steady level starts before edge 8 -> rise at 13
    bounce = 13'b1_1111_1011_1011;  // bit k = raw[3] before edge k+1
    for (int e = 1; e <= 15; e++) begin
      raw[3] = (e <= 13) ? bounce[e-1] : 1'b1;
      tick();
      expect_out($sformatf("bounce3_edge%0d", e),
                 (e >= 13) ? 10'h009 : 10'h001,
                 (e == 13) ? 10'h008 : 10'h000,
                 10'h000, e == 13);
    end

    // 4: KEY0 pressed (active-low) for 10 cycles, then released
    for (int e = 1; e <= 18; e++) begin
      raw[8] = (e <= 10) ? 1'b0 : 1'b1;
      tick();
      s_exp = (e >= 6 && e <= 15) ? 10'h109 : 10'h009;
      r_exp = (e == 6)  ? 10'h100 : 10'h000;
      f_exp = (e == 16) ? 10'h100 : 10'h000;
      expect_out($sformatf("key0_edge%0d", e), s_exp, r_exp, f_exp, (e == 6) || (e == 16));
    end

    // 5: raw[1] and raw[7] change together
    raw[1] = 1'b1;
    raw[7] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      expect_out($sformatf("dual_edge%0d", e),
                 (e >= 6) ? 10'h08B : 10'h009,
                 (e == 6) ? 10'h082 : 10'h000,
                 10'h000, e == 6);
    end

    // 6: reset aborts raw[2] at count 2; all held-high bits re-accepted later
    raw[2] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      expect_out($sformatf("abort_pre_edge%0d", e), 10'h08B, 10'h000, 10'h000, 1'b0);
    end
    reset = 1'b1;
    #1;
    expect_out("abort_reset_async", 10'h000, 10'h000, 10'h000, 1'b0);
    for (int e = 1; e <= 2; e++) begin
      tick();
      expect_out($sformatf("abort_reset_hold_%0d", e), 10'h000, 10'h000, 10'h000, 1'b0);
    end
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      expect_out($sformatf("post_reset_edge%0d", e),
                 (e >= 6) ? 10'h08F : 10'h000,
                 (e == 6) ? 10'h08F : 10'h000,
                 10'h000, e == 6);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
